median_filter_nxn: RTL and testbench



---
 rtl/median_filter_nxn.sv | 169 ++++++++++++++++
 tb/tb_median_filter_nxn.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/median_filter_nxn.sv
// Streaming exact 3x3 median filter with valid/ready on both sides.
// Emits the cropped (IMAGE_HEIGHT-2) x (IMAGE_LEN-2) interior, one median per channel.

module median_filter_bram #(
  parameter int DEPTH = 4,
  parameter int W     = 8,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem [DEPTH];

  // Read-first: a same-address write in this cycle returns the old word.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// 5th smallest of nine values: each element's rank breaks ties by index,
// so exactly one element lands on rank 4.
module median_filter_med9 #(
  parameter int W = 8
) (
  input  logic [8:0][W-1:0] v,
  output logic [W-1:0]      med
);
  logic [8:0][3:0] rank;

  always_comb begin
    rank = '0;
    med  = '0;
    for (int i = 0; i < 9; i++)
      for (int j = 0; j < 9; j++)
        if (j != i && (v[j] < v[i] || (v[j] == v[i] && j < i)))
          rank[i] = rank[i] + 4'd1;
    for (int i = 0; i < 9; i++)
      if (rank[i] == 4'd4) med = v[i];
  end
endmodule

module median_filter_nxn #(
  parameter int  IMAGE_LEN    = 1080,
  parameter int  IMAGE_HEIGHT = 720,
  parameter int  NUM_CHANNELS = 3,
  parameter int  PIXEL_W      = 8,
  localparam int DATA_W       = NUM_CHANNELS * PIXEL_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              in_valid_i,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              in_ready_o,
  output logic              out_valid_o,
  output logic [DATA_W-1:0] out_data_o,
  input  logic              out_ready_i,
  output logic              done_o
);
  localparam int COL_W = $clog2(IMAGE_LEN);
  localparam int ROW_W = $clog2(IMAGE_HEIGHT);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state, state_nxt;

  logic              adv, accept, last_pix;
  logic [COL_W-1:0]  col, s1_col;
  logic [ROW_W-1:0]  row;
  logic              s1_vld, s1_emit, s2_vld;
  logic [DATA_W-1:0] s1_pix, l1_rd, l2_rd, med;
  logic [2:0][2:0][DATA_W-1:0] win;  // [row][col]; row 0 = r-2, col 2 = newest

  assign adv        = !out_valid_o || out_ready_i;
  assign in_ready_o = (state == RUN) && adv;
  assign accept     = in_valid_i && in_ready_o;
  assign last_pix   = (row == ROW_W'(IMAGE_HEIGHT - 1)) && (col == COL_W'(IMAGE_LEN - 1));
  assign done_o     = (state == DONE);

  // line1 holds the current row; line2 takes line1's old word one stage later.
  median_filter_bram #(.DEPTH(IMAGE_LEN), .W(DATA_W), .AW(COL_W)) u_line1 (
    .clk(clk), .we(accept), .waddr(col), .wdata(in_data_i),
    .re(accept), .raddr(col), .rdata(l1_rd)
  );

  median_filter_bram #(.DEPTH(IMAGE_LEN), .W(DATA_W), .AW(COL_W)) u_line2 (
    .clk(clk), .we(adv && s1_vld), .waddr(s1_col), .wdata(l1_rd),
    .re(accept), .raddr(col), .rdata(l2_rd)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start_i) state_nxt = RUN;
      RUN:   if (accept && last_pix) state_nxt = DRAIN;
      DRAIN: if (out_valid_o && out_ready_i && !(s1_vld && s1_emit) && !s2_vld)
               state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst || (state == IDLE && start_i)) begin
      row <= '0;
      col <= '0;
    end else if (accept) begin
      if (col == COL_W'(IMAGE_LEN - 1)) begin
        col <= '0;
        if (row != ROW_W'(IMAGE_HEIGHT - 1)) row <= row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // Three adv-gated stages: line-buffer read, window shift, median/output.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld      <= 1'b0;
      s1_emit     <= 1'b0;
      s1_col      <= '0;
      s1_pix      <= '0;
      s2_vld      <= 1'b0;
      win         <= '0;
      out_valid_o <= 1'b0;
      out_data_o  <= '0;
    end else if (adv) begin
      s1_vld <= accept;
      if (accept) begin
        s1_pix  <= in_data_i;
        s1_col  <= col;
        s1_emit <= (row >= ROW_W'(2)) && (col >= COL_W'(2));
      end
      s2_vld <= s1_vld && s1_emit;
      if (s1_vld) begin
        for (int i = 0; i < 3; i++) begin
          win[i][0] <= win[i][1];
          win[i][1] <= win[i][2];
        end
        win[0][2] <= l2_rd;
        win[1][2] <= l1_rd;
        win[2][2] <= s1_pix;
      end
      out_valid_o <= s2_vld;
      if (s2_vld) out_data_o <= med;
    end
  end

  for (genvar k = 0; k < NUM_CHANNELS; k++) begin : g_ch
    logic [8:0][PIXEL_W-1:0] v;
    for (genvar i = 0; i < 3; i++) begin : g_r
      for (genvar j = 0; j < 3; j++) begin : g_c
        assign v[3*i+j] = win[i][j][k*PIXEL_W +: PIXEL_W];
      end
    end
    median_filter_med9 #(.W(PIXEL_W)) u_med (.v(v), .med(med[k*PIXEL_W +: PIXEL_W]));
  end
endmodule

// File: tb/tb_median_filter_nxn.sv
// Directed bench: 4x3 frames with hand-computed medians, 8x6 random frames
// against a sort-based model, backpressure, restart and mid-frame reset.
module tb_median_filter_nxn;
  localparam int DW = 24;

  logic clk = 1'b0;
  logic rst, sel, start, in_valid, out_ready;
  logic [DW-1:0] in_data;
  logic [1:0] ir, ov, dn;
  logic [1:0][DW-1:0] od;
  logic cur_ir, cur_ov, cur_dn;
  logic [DW-1:0] cur_od;

  always #5 clk = ~clk;

  median_filter_nxn #(.IMAGE_LEN(4), .IMAGE_HEIGHT(3), .NUM_CHANNELS(3), .PIXEL_W(8)) u_small (
    .clk(clk), .rst(rst), .start_i(start && !sel), .in_valid_i(in_valid && !sel),
    .in_data_i(in_data), .in_ready_o(ir[0]), .out_valid_o(ov[0]), .out_data_o(od[0]),
    .out_ready_i(out_ready), .done_o(dn[0])
  );

  median_filter_nxn #(.IMAGE_LEN(8), .IMAGE_HEIGHT(6), .NUM_CHANNELS(3), .PIXEL_W(8)) u_big (
    .clk(clk), .rst(rst), .start_i(start && sel), .in_valid_i(in_valid && sel),
    .in_data_i(in_data), .in_ready_o(ir[1]), .out_valid_o(ov[1]), .out_data_o(od[1]),
    .out_ready_i(out_ready), .done_o(dn[1])
  );

  assign cur_ir = ir[sel];
  assign cur_ov = ov[sel];
  assign cur_dn = dn[sel];
  assign cur_od = od[sel];

  int n_chk = 0;
  int n_err = 0;
  logic [DW-1:0] img [64];
  logic [DW-1:0] exp_q [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] sw_med(input int L, input int r, input int c);
    logic [7:0] v [9];
    logic [7:0] t;
    logic [DW-1:0] res;
    logic [DW-1:0] p;
    res = '0;
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++) begin
          p = img[(r - 1 + i) * L + (c - 1 + j)];
          v[3*i+j] = p[k*8 +: 8];
        end
      for (int a = 0; a < 8; a++)
        for (int b = 0; b < 8 - a; b++)
          if (v[b] > v[b+1]) begin
            t = v[b]; v[b] = v[b+1]; v[b+1] = t;
          end
      res[k*8 +: 8] = v[4];
    end
    return res;
  endfunction

  task automatic fill_rand(input int L, input int H);
    for (int i = 0; i < L * H; i++) img[i] = DW'($urandom);
    for (int r = 1; r < H - 1; r++)
      for (int c = 1; c < L - 1; c++) exp_q.push_back(sw_med(L, r, c));
  endtask

  // Streams img through the selected DUT; checks outputs in order against exp_q.
  task automatic run_frame(input int L, input int H, input bit rnd_ready,
                           input int abort_pi, input int restart_cyc, input bit chk_lat);
    int pi, nout, cyc, ndone, last_hs, acc_cyc, first_ov, tail, nexp;
    bit stalled;
    logic [DW-1:0] held;
    nexp = exp_q.size();
    pi = 0; nout = 0; cyc = 0; ndone = 0; last_hs = -10;
    acc_cyc = -100; first_ov = -1; tail = 0; stalled = 0; held = '0;
    while (cyc < 3000 && tail < 3) begin
      @(negedge clk);
      start     = (cyc == 0) || (cyc == restart_cyc);
      out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      in_valid  = (pi < L * H);
      in_data   = in_valid ? img[pi] : '0;
      #1;
      if (cur_dn) begin
        ndone++;
        if (ndone == 1) chk("done_lat", cyc - last_hs, 1);
      end
      if (ndone > 0) tail++;
      if (stalled) begin
        chk("stall_vld", 32'(cur_ov), 1);
        chk("stall_hold", 32'(cur_od), 32'(held));
      end
      stalled = 0;
      if (cur_ov) begin
        if (first_ov < 0) first_ov = cyc;
        if (out_ready) begin
          if (exp_q.size() > 0) chk("pix", 32'(cur_od), 32'(exp_q.pop_front()));
          else chk("extra_out", 1, 0);
          nout++;
          last_hs = cyc;
        end else begin
          stalled = 1;
          held = cur_od;
        end
      end
      if (in_valid && cur_ir) begin
        if (pi == 2 * L + 2) acc_cyc = cyc;
        pi++;
        if (pi == abort_pi) break;
      end
      cyc++;
    end
    start = 1'b0;
    if (abort_pi > 0) begin
      chk("abort_done", ndone, 0);
    end else begin
      chk("nout", nout, nexp);
      chk("ndone", ndone, 1);
      if (chk_lat) chk("latency", first_ov - acc_cyc, 3);
    end
  endtask

  task automatic chk_quiet(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      #1;
      chk({tag, "_rdy"}, 32'(cur_ir), 0);
      chk({tag, "_ov"}, 32'(cur_ov), 0);
      chk({tag, "_done"}, 32'(cur_dn), 0);
    end
  endtask

  initial begin
    logic [7:0] v, imp, ramp;
    rst = 1'b1; sel = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_data = '0;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      chk("rst_rdy", 32'(ir[s]), 0);
      chk("rst_ov", 32'(ov[s]), 0);
      chk("rst_od", 32'(od[s]), 0);
      chk("rst_done", 32'(dn[s]), 0);
    end
    rst = 1'b0;

    // 4x3 impulse: the 255 at (1,1) is rejected by both windows.
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 4; c++) begin
        v = (r == 1 && c == 1) ? 8'd255 : 8'd10;
        img[r*4+c] = {3{v}};
      end
    exp_q.push_back({3{8'd10}});
    exp_q.push_back({3{8'd10}});
    run_frame(4, 3, 0, 0, -1, 0);

    // 4x3 ramp 4r+c: medians 5 and 6.
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 4; c++) begin
        v = 8'(4 * r + c);
        img[r*4+c] = {3{v}};
      end
    exp_q.push_back({3{8'd5}});
    exp_q.push_back({3{8'd6}});
    run_frame(4, 3, 0, 0, -1, 1);

    // Per-channel mix: ch0 const 7, ch1 255-ramp, ch2 impulse.
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 4; c++) begin
        ramp = 8'(4 * r + c);
        imp  = (r == 1 && c == 1) ? 8'd255 : 8'd10;
        img[r*4+c] = {imp, 8'd255 - ramp, 8'd7};
      end
    exp_q.push_back({8'd10, 8'd250, 8'd7});
    exp_q.push_back({8'd10, 8'd249, 8'd7});
    run_frame(4, 3, 0, 0, -1, 0);

    // No start: valid input must not be accepted.
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = {3{8'd99}};
    chk_quiet("nostart", 6);
    in_valid = 1'b0;

    // Start pulsed mid-RUN is ignored: same two ramp outputs.
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 4; c++) begin
        v = 8'(4 * r + c);
        img[r*4+c] = {3{v}};
      end
    exp_q.push_back({3{8'd5}});
    exp_q.push_back({3{8'd6}});
    run_frame(4, 3, 0, 0, 5, 0);

    // 8x6 random frame under random backpressure.
    @(negedge clk);
    sel = 1'b1;
    fill_rand(8, 6);
    run_frame(8, 6, 1, 0, -1, 0);

    // Abort in row 3, reset, then a clean frame.
    fill_rand(8, 6);
    run_frame(8, 6, 0, 3 * 8 + 3, -1, 0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_od", 32'(cur_od), 0);
    chk_quiet("abort", 6);
    fill_rand(8, 6);
    run_frame(8, 6, 1, 0, -1, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
